// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate truth-table sweeper: FSM encoding and limits.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EMIT   = 2'd2,
    DONE   = 2'd3
  } sweep_state_t;

  localparam int MAX_N_IN = 4;

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter; expire flags the last cycle of a settle interval (count==1).
module sweep_settle_timer #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  // Stops at zero so an idle timer never re-expires on its own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expire = (cnt == CNT_W'(1));

endmodule

// File: rtl/gate_truth_table_sweeper.sv
// Drives every input combination of a gate under test, samples its output after a
// settle delay, emits each row over valid/ready and accumulates the full truth table.
module gate_truth_table_sweeper
  import gate_sweep_pkg::*;
#(
  parameter int N_IN          = 1,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      gate_in,
  input  logic                 gate_out,
  output logic                 busy,
  output logic                 row_valid,
  input  logic                 row_ready,
  output logic [N_IN-1:0]      row_idx,
  output logic                 row_out,
  output logic [(1<<N_IN)-1:0] table_out,
  output logic                 done
);

  localparam int              ROWS  = 1 << N_IN;
  localparam int              CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [N_IN-1:0] LAST  = N_IN'(ROWS - 1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end
  if (N_IN < 1 || N_IN > MAX_N_IN) begin : g_bad_n_in
    $error("N_IN out of range 1..MAX_N_IN");
  end

  sweep_state_t        state_q, state_d;
  logic [N_IN-1:0]     gate_in_d, row_idx_d;
  logic [ROWS-1:0]     table_d;
  logic                row_out_d, busy_d, row_valid_d, done_d;
  logic                load, expire;

  sweep_settle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (CNT_W'(SETTLE_CYCLES)),
    .expire   (expire)
  );

  always_comb begin
    state_d     = state_q;
    gate_in_d   = gate_in;
    row_idx_d   = row_idx;
    row_out_d   = row_out;
    table_d     = table_out;
    busy_d      = busy;
    row_valid_d = row_valid;
    done_d      = 1'b0;
    load        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          gate_in_d = '0;
          row_idx_d = '0;
          table_d   = '0;
          load      = 1'b1;
          busy_d    = 1'b1;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        // gate_out is only ever observed here, on the final settle cycle.
        if (expire) begin
          row_out_d          = gate_out;
          table_d[row_idx]   = gate_out;
          row_valid_d        = 1'b1;
          state_d            = EMIT;
        end
      end
      EMIT: begin
        if (row_valid && row_ready) begin
          row_valid_d = 1'b0;
          if (row_idx == LAST) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            row_idx_d = row_idx + N_IN'(1);
            gate_in_d = row_idx + N_IN'(1);
            load      = 1'b1;
            state_d   = SETTLE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gate_in   <= '0;
      row_idx   <= '0;
      row_out   <= 1'b0;
      table_out <= '0;
      busy      <= 1'b0;
      row_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_in   <= gate_in_d;
      row_idx   <= row_idx_d;
      row_out   <= row_out_d;
      table_out <= table_d;
      busy      <= busy_d;
      row_valid <= row_valid_d;
      done      <= done_d;
    end
  end

endmodule
